// File: rtl/split_eval_pkg.sv
// Shared types and helpers for the split-stage constraint evaluator arbiter.
// Provides the FSM state type, the statistics width and the round-robin grant search.
package split_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 32;

  // First set bit of valid at or after ptr, wrapping at num_req; returns ptr if none is set.
  function automatic int unsigned next_rr(input int unsigned ptr,
                                          input logic [MAX_REQ-1:0] valid,
                                          input int unsigned num_req);
    int unsigned idx;
    logic        found;
    next_rr = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) begin
        idx = ptr + i;
        if (idx >= num_req) begin
          idx = idx - num_req;
        end
        if (!found && valid[idx]) begin
          next_rr = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/split_constraint_eval.sv
// Shared combinational constraint evaluator: sat = |((~v) >> SHIFT).
module split_constraint_eval
  import split_eval_pkg::*;
#(
  parameter int VAR_W = 15,
  parameter int SHIFT = 10
) (
  input  logic [VAR_W-1:0] v,
  output logic             sat
);

  logic [VAR_W-1:0] inv_s;

  assign inv_s = ~v;
  assign sat   = |(inv_s >> SHIFT);

endmodule

// File: rtl/split_eval_arbiter.sv
// Round-robin arbiter sharing one constraint evaluator among NUM_REQ requesters.
// Optional hit/miss statistics are enabled by defining SPLIT_EVAL_STATS_EN.
module split_eval_arbiter
  import split_eval_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VAR_W   = 15,
  parameter int SHIFT   = 10,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VAR_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_sat,
  output logic [STAT_W-1:0]        sat_count,
  output logic [STAT_W-1:0]        unsat_count
);

  state_e             state_r, state_next_s;
  logic [ID_W-1:0]    rr_ptr_r, id_r, resp_id_r, grant_s, ptr_next_s;
  logic [VAR_W-1:0]   op_r, grant_data_s;
  logic [MAX_REQ-1:0] valid_ext_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               any_valid_s, sat_s, handshake_s;
  logic               resp_valid_r, resp_sat_r;

  assign valid_ext_s  = MAX_REQ'(req_valid);
  assign grant_s      = ID_W'(next_rr(32'(rr_ptr_r), valid_ext_s, NUM_REQ));
  assign grant_data_s = req_data[grant_s*VAR_W +: VAR_W];
  assign any_valid_s  = |req_valid;
  assign ptr_next_s   = (grant_s == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : grant_s + 1'b1;
  assign handshake_s  = (state_r == RESP) && resp_valid_r && resp_ready;

  split_constraint_eval #(
    .VAR_W(VAR_W),
    .SHIFT(SHIFT)
  ) u_eval (
    .v  (op_r),
    .sat(sat_s)
  );

  // Next-state and grant decode; no grant is offered while reset is asserted.
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = '0;
    case (state_r)
      IDLE: begin
        if (any_valid_s && rst_n) begin
          req_ready_s[grant_s] = 1'b1;
          state_next_s         = EVAL;
        end else begin
          state_next_s = IDLE;
        end
      end
      EVAL: state_next_s = RESP;
      RESP: begin
        if (handshake_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      op_r         <= '0;
      id_r         <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_sat_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            op_r     <= grant_data_s;
            id_r     <= grant_s;
            rr_ptr_r <= ptr_next_s;
          end
        end
        EVAL: begin
          resp_sat_r   <= sat_s;
          resp_id_r    <= id_r;
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          if (handshake_s) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_sat   = resp_sat_r;

`ifdef SPLIT_EVAL_STATS_EN
  logic [STAT_W-1:0] sat_count_r, unsat_count_r;

  // Saturating result counters, updated once per response handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count_r   <= '0;
      unsat_count_r <= '0;
    end else if (handshake_s) begin
      if (resp_sat_r) begin
        if (sat_count_r != {STAT_W{1'b1}}) begin
          sat_count_r <= sat_count_r + 16'd1;
        end
      end else begin
        if (unsat_count_r != {STAT_W{1'b1}}) begin
          unsat_count_r <= unsat_count_r + 16'd1;
        end
      end
    end
  end

  assign sat_count   = sat_count_r;
  assign unsat_count = unsat_count_r;
`else
  assign sat_count   = 16'h0;
  assign unsat_count = 16'h0;
`endif

endmodule

// File: tb/tb_split_eval_arbiter.sv
// Randomized self-checking bench for split_eval_arbiter against a transaction-level model.
module tb_split_eval_arbiter;
  localparam int NUM_REQ = 4;
  localparam int VAR_W   = 15;
  localparam int SHIFT   = 10;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid, req_ready;
  logic [NUM_REQ*VAR_W-1:0] req_data;
  logic                     resp_valid, resp_ready, resp_sat;
  logic [ID_W-1:0]          resp_id;
  logic [15:0]              sat_count, unsat_count;

  always #5 clk = ~clk;

  split_eval_arbiter #(.NUM_REQ(NUM_REQ), .VAR_W(VAR_W), .SHIFT(SHIFT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sat(resp_sat), .sat_count(sat_count), .unsat_count(unsat_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // requester side and reference model state
  bit               pending[NUM_REQ];
  logic [VAR_W-1:0] pdata[NUM_REQ];
  int               ptr, m_id, g_idx, m_satc, m_unsatc;
  bit               busy, out_valid, m_sat;
  logic [VAR_W-1:0] g_data;
  int               p_new, p_drop, p_ready;
  bit               rst_req;
  int               grants[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // sat is 1 unless every bit that survives the shift of the inverted operand is zero
  function automatic bit ref_sat(input logic [VAR_W-1:0] d);
    int inv;
    inv = (1 << VAR_W) - 1 - int'(d);
    return (inv >> SHIFT) != 0;
  endfunction

  function automatic logic [VAR_W-1:0] pick_data();
    case ($urandom_range(5))
      0: return 15'h0000;
      1: return 15'h7FFF;
      2: return 15'h7C00;
      3: return 15'h03FF;
      4: return {5'h1F, 10'($urandom)};
      default: return 15'($urandom);
    endcase
  endfunction

  function automatic bit any_pending();
    bit a = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) a |= pending[i];
    return a;
  endfunction

  task automatic step();
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pending[i]) begin
        if (int'($urandom_range(99)) < p_new) begin
          pending[i] = 1'b1;
          pdata[i]   = pick_data();
        end
      end else if (int'($urandom_range(99)) < p_drop) begin
        pending[i] = 1'b0;
      end
      req_valid[i] = pending[i];
      req_data[i*VAR_W +: VAR_W] = pdata[i];
    end
    resp_ready = int'($urandom_range(99)) < p_ready;
    rst_n      = !rst_req;
    #1;
    g = -1;
    if (rst_n && !busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (ptr + k) % NUM_REQ;
        if (g < 0 && pending[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("resp_valid", 32'(resp_valid), 32'(out_valid));
    check_eq("resp_id", 32'(resp_id), 32'(m_id));
    check_eq("resp_sat", 32'(resp_sat), 32'(m_sat));
`ifdef SPLIT_EVAL_STATS_EN
    check_eq("sat_count", 32'(sat_count), 32'(m_satc));
    check_eq("unsat_count", 32'(unsat_count), 32'(m_unsatc));
`else
    check_eq("sat_count", 32'(sat_count), 32'd0);
    check_eq("unsat_count", 32'(unsat_count), 32'd0);
`endif
    // model advance across the coming rising edge
    if (!rst_n) begin
      if (busy) begin
        pending[g_idx] = 1'b1;
        pdata[g_idx]   = g_data;
      end
      busy = 1'b0; out_valid = 1'b0; ptr = 0; m_id = 0; m_sat = 1'b0;
      m_satc = 0; m_unsatc = 0;
    end else if (busy) begin
      if (!out_valid) begin
        out_valid = 1'b1;
        m_id      = g_idx;
        m_sat     = ref_sat(g_data);
      end else if (resp_ready) begin
        out_valid = 1'b0;
        busy      = 1'b0;
        if (m_sat) begin
          if (m_satc < 65535) m_satc++;
        end else begin
          if (m_unsatc < 65535) m_unsatc++;
        end
      end
    end else if (g >= 0) begin
      busy       = 1'b1;
      g_idx      = g;
      g_data     = pdata[g];
      pending[g] = 1'b0;
      ptr        = (g + 1) % NUM_REQ;
      grants.push_back(g);
    end
  endtask

  task automatic run_idle(input int maxc);
    int c = 0;
    while ((busy || any_pending()) && c < maxc) begin
      step();
      c++;
    end
    check_eq("drain_timeout", 32'(c >= maxc), 32'd0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
  endtask

  task automatic one_req(input int r, input logic [VAR_W-1:0] d);
    pending[r] = 1'b1;
    pdata[r]   = d;
    run_idle(30);
  endtask

  initial begin
    logic [VAR_W-1:0] stat_vals[5];
    rst_n = 1'b0; resp_ready = 1'b1; req_valid = '0; req_data = '0;
    p_new = 0; p_drop = 0; p_ready = 100; rst_req = 1'b1;
    ptr = 0; m_id = 0; g_idx = 0; m_satc = 0; m_unsatc = 0;
    busy = 1'b0; out_valid = 1'b0; m_sat = 1'b0; g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin pending[i] = 1'b0; pdata[i] = '0; end

    do_reset();
    one_req(0, 15'h0000);
    one_req(2, 15'h7FFF);
    one_req(1, 15'h7C00);
    one_req(3, 15'h03FF);

    // all requesters valid continuously: strict rotation from 0
    do_reset();
    grants.delete();
    p_new = 100;
    repeat (26) step();
    for (int k = 0; k < 8; k++) check_eq("rotation", 32'(grants[k]), 32'(k % NUM_REQ));
    p_new = 0;
    run_idle(40);

    // consumer stall in RESP
    p_ready = 0;
    pending[1] = 1'b1; pdata[1] = 15'h7C00;
    repeat (8) step();
    p_ready = 100;
    run_idle(20);

    // reset while the evaluation is in flight, then re-grant from pointer 0
    pending[3] = 1'b1; pdata[3] = 15'h03FF;
    grants.delete();
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    run_idle(20);
    check_eq("regrant_cnt", 32'(grants.size()), 32'd2);
    check_eq("regrant_id", 32'(grants[grants.size()-1]), 32'd3);

    // statistics: three sat, two unsat
    do_reset();
    stat_vals = '{15'h0000, 15'h03FF, 15'h1234, 15'h7FFF, 15'h7C00};
    for (int k = 0; k < 5; k++) one_req(k % NUM_REQ, stat_vals[k]);
`ifdef SPLIT_EVAL_STATS_EN
    check_eq("sat_total", 32'(sat_count), 32'd3);
    check_eq("unsat_total", 32'(unsat_count), 32'd2);
    force dut.sat_count_r = 16'hFFFF;
    #1;
    release dut.sat_count_r;
    m_satc = 65535;
    one_req(2, 15'h0000);
    check_eq("sat_saturate", 32'(sat_count), 32'h0000FFFF);
`else
    check_eq("sat_total", 32'(sat_count), 32'd0);
    check_eq("unsat_total", 32'(unsat_count), 32'd0);
`endif

    // randomized traffic with sporadic resets
    p_new = 30; p_drop = 5; p_ready = 70;
    repeat (3000) begin
      rst_req = ($urandom_range(499) == 0);
      step();
    end
    rst_req = 1'b0; p_new = 0; p_drop = 0; p_ready = 100;
    run_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
